sample_streamer: RTL
====================

# sample_streamer

Playback stage downstream of the cellular-RAM controller in the synthesiser. Fetches 16-bit sample words from external RAM over a request/acknowledge read port, buffers them in a small FIFO, and releases one sample per sample-rate tick to the audio output path (PWM/DAC). Supports one-shot and looped playback of an address window. Reports underruns and end of playback.

## Interface
- `SAMPLE_DIV`, 2268: clocks per sample tick (100 MHz / 2268 ≈ 44.1 kHz); must be ≥ 2.
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥ 2.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request. A rising edge starts playback; low stops it.
- `loop`  in  1  1 = wrap to `start_addr` after `end_addr`; 0 = one-shot. Sampled continuously.
- `start_addr`  in  26  first word address. Captured on the `enable` rising edge.
- `end_addr`  in  26  last word address, inclusive. Captured on the `enable` rising edge. Must satisfy `end_addr` ≥ `start_addr`.
- `rd_req`  out  1  read request to the RAM controller.
- `rd_addr`  out  26  word address; stable while `rd_req` is high.
- `rd_ack`  in  1  one-cycle pulse: `rd_data` is valid this cycle.
- `rd_data`  in  16  read data.
- `sample`  out  16  current output sample; holds between ticks.
- `sample_valid`  out  1  one-cycle pulse when `sample` is updated.
- `underrun`  out  1  sticky. Set when a tick finds the FIFO empty while playback is still fetching.
- `busy`  out  1  playback active.
- `done`  out  1  sticky. One-shot playback has completed.

## Operation
- State machine:
  - IDLE → on `enable` rise: capture the addresses, set `addr` = `start_addr`, flush the FIFO, clear the divider, `underrun`, `done` and the end flag. Go to FILL.
  - FILL: assert `rd_req` whenever `addr_end_flag` = 0 and FIFO occupancy plus outstanding reads is less than `FIFO_DEPTH`.
  - `busy` = 1 in every state except IDLE.
- Read handshake:
  - Raise `rd_req` with `rd_addr` = `addr`.
  - Hold both until `rd_ack` = 1.
  - Drop `rd_req` in the cycle after the ack. At most one read is outstanding.
  - An `rd_ack` while `rd_req` = 0 is ignored.
- On `rd_ack`:
  - Push `rd_data` into the FIFO.
  - If `addr` = `end_addr`: if `loop`, set `addr` = `start_addr`; otherwise set `addr_end_flag`. Otherwise `addr` + 1, modulo 2^26.
- Divider: while `busy`, counts `SAMPLE_DIV`−1 down to 0. Tick at 0, then reload.
- On tick:
  - FIFO non-empty: pop, set `sample` = popped word, pulse `sample_valid`.
  - FIFO empty and `addr_end_flag` = 0: set `underrun`; `sample` holds; no pulse.
  - FIFO empty and `addr_end_flag` = 1: set `done`, return to IDLE.
- A push and a pop in the same cycle: both happen, occupancy unchanged.
- `enable` falls mid-playback:
  - Go to DRAIN. Keep any outstanding `rd_req` until its ack, then discard that data.
  - Flush the FIFO and go to IDLE.
  - `sample` holds its value. `done` is not set.
- `enable` rises while in DRAIN: acted on only after returning to IDLE, and only if `enable` is still high. IDLE treats a high level as a start.

## Timing
- Reset values: `rd_req` = 0, `rd_addr` = 0, `sample` = 0, `sample_valid` = 0, `underrun` = 0, `busy` = 0, `done` = 0; FIFO empty; state IDLE.
- `rd_req` rises one cycle after the `enable` rise is seen (cycle 1).
- `rd_addr` and `rd_req` are registered outputs.
- `sample_valid` and the new `sample` are registered and appear in the cycle after the tick.
- The first tick occurs `SAMPLE_DIV` cycles after the start.
- With a RAM latency of L cycles, the FIFO fills in about `FIFO_DEPTH` × (L+2) cycles, which must be much less than `SAMPLE_DIV`.
- One-shot of N words: `done` and `busy` = 0 occur on tick N+1. N valid samples are produced.
- Async reset mid-read: `rd_req` drops immediately. The RAM controller is reset by the same `rst`.

## Test plan
- Start at 0x10, end at 0x13, loop=0, RAM returns data = address, ack latency 3 → exactly 4 `sample_valid` pulses, values 0x10..0x13, spaced 2268 cycles; then `done` = 1, `busy` = 0; `underrun` stays 0.
- Same window with loop=1, run for 10 ticks → samples 0x10,0x11,0x12,0x13,0x10,…,0x11; `rd_addr` wraps 0x13→0x10; `done` stays 0.
- Ack latency forced to 3000 cycles → `underrun` sets on the first tick; `sample` stays 0; no pulse; playback continues once data arrives.
- Drop `enable` while `rd_req` is high, ack 5 cycles later → `rd_req` drops after the ack; FIFO empty; `busy` = 0 the cycle after; no further `sample_valid`.
- End = start = 0x3FFFFFF, loop=1 → every read is to 0x3FFFFFF with no overflow; constant sample stream.
- Assert `rst` asynchronously mid-playback (between clock edges) → all outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/sample_streamer.sv
// sample_streamer
// Playback stage behind the cellular-RAM controller. Fetches 16-bit sample
// words from an address window over a req/ack read port and buffers them in
// a small FIFO. It releases one word per sample-rate tick to the audio path.
// Supports one-shot and looped playback, and flags underruns and completion.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   enable            run request; rising edge starts, low stops playback
//   loop              1 = wrap to start_addr after end_addr, 0 = one-shot
//   start_addr        first word address, captured at start
//   end_addr          last word address (inclusive), captured at start
//   rd_req, rd_addr   registered read request / word address to the RAM
//   rd_ack, rd_data   one-cycle acknowledge with the read data
//   sample            current output sample, holds between ticks
//   sample_valid      one-cycle pulse when sample is updated
//   underrun          sticky: a tick found the FIFO empty while fetching
//   busy              playback active (any state but idle)
//   done              sticky: one-shot playback has completed
module sample_streamer #(
  parameter int SAMPLE_DIV = 2268,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        loop,
  input  logic [25:0] start_addr,
  input  logic [25:0] end_addr,
  output logic        rd_req,
  output logic [25:0] rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        underrun,
  output logic        busy,
  output logic        done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [25:0]      start_r;
  logic [25:0]      end_r;
  logic [25:0]      addr;
  logic             addr_end_flag;
  logic             armed;

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic [DIV_W-1:0] div_cnt;

  logic tick;
  logic ack_take;
  logic start;
  logic push;
  logic pop;
  logic flush;
  logic issue;
  logic set_underrun;
  logic set_done;

  assign busy     = (state != ST_IDLE);
  assign tick     = busy && (div_cnt == '0);
  assign ack_take = rd_req && rd_ack;

  // State register for the playback controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle strobes. A start needs enable high while armed,
  // and armed is only set once enable has been seen low. So a finished
  // one-shot with enable still high stays idle. A restart requested during
  // DRAIN is honoured as soon as we are back in idle. Reads acknowledged
  // after enable falls are not pushed, so their data is dropped.
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    issue        = 1'b0;
    set_underrun = 1'b0;
    set_done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && armed) begin
          start      = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!enable) begin
          state_next = ST_DRAIN;
        end else begin
          push = ack_take;
          if (tick) begin
            if (fifo_count != '0) begin
              pop = 1'b1;
            end else if (!addr_end_flag) begin
              set_underrun = 1'b1;
            end else begin
              set_done   = 1'b1;
              state_next = ST_IDLE;
            end
          end
          issue = !rd_req && !addr_end_flag && (fifo_count < FIFO_FULL);
        end
      end
      ST_DRAIN: begin
        if (!rd_req || rd_ack) begin
          flush      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Start latch: armed drops when a playback starts and is re-armed by any
  // cycle with enable low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b1;
    end else if (start) begin
      armed <= 1'b0;
    end else if (!enable) begin
      armed <= 1'b1;
    end
  end

  // Read port and fetch address. The first read goes out on the start edge
  // itself. Afterwards rd_req is held until its ack, dropped for at least
  // one cycle, and re-raised only when the FIFO has room. Since at most one
  // read is outstanding, checking rd_req low accounts for in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_req        <= 1'b0;
      rd_addr       <= '0;
      start_r       <= '0;
      end_r         <= '0;
      addr          <= '0;
      addr_end_flag <= 1'b0;
    end else begin
      if (start) begin
        start_r       <= start_addr;
        end_r         <= end_addr;
        addr          <= start_addr;
        addr_end_flag <= 1'b0;
      end else if (push) begin
        if (addr == end_r) begin
          if (loop) begin
            addr <= start_r;
          end else begin
            addr_end_flag <= 1'b1;
          end
        end else begin
          addr <= addr + 26'd1;
        end
      end

      if (start) begin
        rd_req  <= 1'b1;
        rd_addr <= start_addr;
      end else if (ack_take) begin
        rd_req <= 1'b0;
      end else if (issue) begin
        rd_req  <= 1'b1;
        rd_addr <= addr;
      end
    end
  end

  // FIFO storage; no reset needed because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rd_data;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the
  // occupancy unchanged. Start and drain both empty it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (start || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Sample-rate divider. It is reloaded on start, so the first tick lands
  // exactly SAMPLE_DIV cycles after the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (start) begin
      div_cnt <= DIV_RELOAD;
    end else if (busy) begin
      if (div_cnt == '0) begin
        div_cnt <= DIV_RELOAD;
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

  // Output sample and status flags. The sample only changes on a pop, so it
  // holds through underruns, stops and completion. Both status flags are
  // sticky until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      done         <= 1'b0;
    end else begin
      sample_valid <= pop;
      if (pop) begin
        sample <= fifo_mem[rd_ptr];
      end
      if (start) begin
        underrun <= 1'b0;
        done     <= 1'b0;
      end else begin
        if (set_underrun) begin
          underrun <= 1'b1;
        end
        if (set_done) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule
